// File: rtl/fft_bfly_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fft_bfly_addr_gen
//  Purpose  : Stage/butterfly sequencer for an in-place radix-2 DIT FFT.
//             Issues one butterfly per cycle, with read addresses for both
//             legs and a twiddle index. Returns the matching write addresses
//             after BF_LAT cycles. Holds each stage until its writes drain.
//  Revision : 1.0  initial release
// ============================================================================
module fft_bfly_addr_gen #(
  parameter int LOG2N  = 5,
  parameter int BF_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [2:0]       stage,
  output logic             rd_valid,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wr_valid,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int c_dw = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int c_pw = 2 * LOG2N + 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  localparam logic [LOG2N-2:0] c_b_last     = '1;
  localparam logic [LOG2N-2:0] c_b_one      = (LOG2N-1)'(1);
  localparam logic [2:0]       c_stage_last = 3'(LOG2N - 1);
  localparam logic [2:0]       c_tw_top     = 3'(LOG2N - 1);
  localparam logic [c_dw-1:0]  c_d_last     = c_dw'(BF_LAT - 1);
  localparam logic [c_dw-1:0]  c_d_one      = c_dw'(1);
  localparam logic [LOG2N-1:0] c_one        = LOG2N'(1);

  logic [1:0]       r_state;
  logic [LOG2N-2:0] r_b;
  logic [2:0]       r_stage;
  logic [c_dw-1:0]  r_dcnt;

  logic [1:0]       w_state_nx;
  logic [LOG2N-2:0] w_b_nx;
  logic [2:0]       w_stage_nx;
  logic [c_dw-1:0]  w_dcnt_nx;
  logic             w_done_nx;
  logic             w_issue_nx;

  logic [LOG2N-1:0] w_b_ext;
  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_grp;
  logic [LOG2N-1:0] w_addr_a;
  logic [LOG2N-1:0] w_addr_b;
  logic [LOG2N-2:0] w_tw;

  // Write-back delay line: {valid, addr_a, addr_b}, one entry per cycle of latency.
  logic [c_pw-1:0]  r_pipe [BF_LAT];

  // Next-state logic for the IDLE -> ISSUE -> DRAIN -> (ISSUE | IDLE) sequence.
  always_comb begin
    w_state_nx = r_state;
    w_b_nx     = r_b;
    w_stage_nx = r_stage;
    w_dcnt_nx  = r_dcnt;
    w_done_nx  = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_state_nx = c_st_issue;
          w_b_nx     = '0;
          w_stage_nx = '0;
        end
      end
      c_st_issue: begin
        if (r_b == c_b_last) begin
          w_state_nx = c_st_drain;
          w_dcnt_nx  = '0;
        end else begin
          w_b_nx = r_b + c_b_one;
        end
      end
      c_st_drain: begin
        if (r_dcnt == c_d_last) begin
          if (r_stage != c_stage_last) begin
            w_state_nx = c_st_issue;
            w_stage_nx = r_stage + 3'd1;
            w_b_nx     = '0;
          end else begin
            w_state_nx = c_st_idle;
            w_stage_nx = '0;
            w_done_nx  = 1'b1;
          end
        end else begin
          w_dcnt_nx = r_dcnt + c_d_one;
        end
      end
      default: begin
        w_state_nx = c_st_idle;
        w_stage_nx = '0;
      end
    endcase
  end

  // Butterfly address/twiddle arithmetic on the next-cycle stage and index,
  // so the registered outputs line up with rd_valid.
  always_comb begin
    w_issue_nx = (w_state_nx == c_st_issue);
    w_b_ext    = {1'b0, w_b_nx};
    w_span     = c_one << w_stage_nx;
    w_pos      = w_b_ext & (w_span - c_one);
    w_grp      = w_b_ext >> w_stage_nx;
    w_addr_a   = (w_grp << (w_stage_nx + 3'd1)) | w_pos;
    w_addr_b   = w_addr_a + w_span;
    // pos < span <= N/2, so it always fits in the twiddle index width.
    w_tw       = w_pos[LOG2N-2:0] << (c_tw_top - w_stage_nx);
  end

  // Sequencer state and registered read-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_st_idle;
      r_b      <= '0;
      r_stage  <= '0;
      r_dcnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      tw_idx   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_b      <= w_b_nx;
      r_stage  <= w_stage_nx;
      r_dcnt   <= w_dcnt_nx;
      busy     <= (w_state_nx != c_st_idle);
      done     <= w_done_nx;
      rd_valid <= w_issue_nx;
      addr_a   <= w_issue_nx ? w_addr_a : '0;
      addr_b   <= w_issue_nx ? w_addr_b : '0;
      tw_idx   <= w_issue_nx ? w_tw     : '0;
    end
  end

  // Shift the issued read pair down the latency line; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BF_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= {rd_valid, addr_a, addr_b};
      for (int i = 1; i < BF_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign stage = r_stage;
  assign {wr_valid, wr_addr_a, wr_addr_b} = r_pipe[BF_LAT-1];

endmodule
`default_nettype wire
